// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back latch, 32x32 register file and operand forwarding
module wb_regfile #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          wreg_i,
    input  logic [AW-1:0] rw_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re1_i,
    input  logic          re2_i,
    input  logic [AW-1:0] raddr1_i,
    input  logic [AW-1:0] raddr2_i,
    output logic [DW-1:0] rdata1_o,
    output logic [DW-1:0] rdata2_o,
    output logic          wb_valid_o,
    output logic [AW-1:0] wb_addr_o,
    output logic [DW-1:0] wb_data_o,
    output logic [31:0]   commit_cnt_o
);

    logic [DW-1:0] regs [NREG];
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [31:0]   commit_cnt;
    logic          commit;
    logic [DW-1:0] arr1;
    logic [DW-1:0] arr2;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < NREG;
    endfunction

    // r0 is hardwired to zero, so a write-back aimed at it is neither stored nor counted
    assign commit = wb_valid && (wb_addr != '0) && in_range(wb_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            commit_cnt <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (commit) begin
                regs[wb_addr] <= wb_data;
                commit_cnt    <= commit_cnt + 32'd1;
            end
            // a stall inserts a bubble; the entry already latched still commits above
            if (stall_i) begin
                wb_valid <= 1'b0;
            end else begin
                wb_valid <= wreg_i;
                wb_addr  <= rw_i;
                wb_data  <= wdata_i;
            end
        end
    end

    function automatic logic [DW-1:0] read_port(
        input logic          rst_v,
        input logic          re,
        input logic [AW-1:0] addr,
        input logic          ex_we,
        input logic [AW-1:0] ex_addr,
        input logic [DW-1:0] ex_data,
        input logic          wb_v,
        input logic [AW-1:0] wb_a,
        input logic [DW-1:0] wb_d,
        input logic [DW-1:0] arr
    );
        if (rst_v || !re || addr == '0) begin
            return '0;
        end
        // the execute result is younger than the WB latch, so it wins a collision
        if (ex_we && ex_addr == addr) begin
            return ex_data;
        end
        if (wb_v && wb_a == addr) begin
            return wb_d;
        end
        return arr;
    endfunction

    always_comb begin
        arr1 = '0;
        arr2 = '0;
        if (in_range(raddr1_i)) begin
            arr1 = regs[raddr1_i];
        end
        if (in_range(raddr2_i)) begin
            arr2 = regs[raddr2_i];
        end
    end

    always_comb begin
        rdata1_o = read_port(rst, re1_i, raddr1_i, wreg_i, rw_i, wdata_i,
                             wb_valid, wb_addr, wb_data, arr1);
        rdata2_o = read_port(rst, re2_i, raddr2_i, wreg_i, rw_i, wdata_i,
                             wb_valid, wb_addr, wb_data, arr2);
    end

    assign wb_valid_o   = wb_valid;
    assign wb_addr_o    = wb_addr;
    assign wb_data_o    = wb_data;
    assign commit_cnt_o = commit_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed vector table plus randomized run against an architectural model
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        wreg_i;
    logic [4:0]  rw_i;
    logic [31:0] wdata_i;
    logic        re1_i;
    logic        re2_i;
    logic [4:0]  raddr1_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata1_o;
    logic [31:0] rdata2_o;
    logic        wb_valid_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] commit_cnt_o;

    int n_checks;
    int n_fail;

    wb_regfile #(.DW(32), .AW(5), .NREG(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .wreg_i       (wreg_i),
        .rw_i         (rw_i),
        .wdata_i      (wdata_i),
        .re1_i        (re1_i),
        .re2_i        (re2_i),
        .raddr1_i     (raddr1_i),
        .raddr2_i     (raddr2_i),
        .rdata1_o     (rdata1_o),
        .rdata2_o     (rdata2_o),
        .wb_valid_o   (wb_valid_o),
        .wb_addr_o    (wb_addr_o),
        .wb_data_o    (wb_data_o),
        .commit_cnt_o (commit_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        wreg;
        logic [4:0]  rw;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic        exp_valid;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[21];

    // architectural model: program-visible register values plus the pending commit
    logic [31:0] arch [32];
    logic        pend_valid;
    logic [4:0]  pend_addr;
    logic [31:0] pend_data;
    logic [31:0] model_cnt;

    function automatic vec_t mk(
        input logic r, input logic s, input logic w, input logic [4:0] a, input logic [31:0] d,
        input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
        input logic [31:0] x1, input logic [31:0] x2, input logic xv, input logic [31:0] xc
    );
        vec_t v;
        v.rst = r; v.stall = s; v.wreg = w; v.rw = a; v.wdata = d;
        v.re1 = e1; v.ra1 = a1; v.re2 = e2; v.ra2 = a2;
        v.exp1 = x1; v.exp2 = x2; v.exp_valid = xv; v.exp_cnt = xc;
        return v;
    endfunction

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic e1, input logic [4:0] a1,
                         input logic e2, input logic [4:0] a2);
        @(negedge clk);
        rst = r; stall_i = s; wreg_i = w; rw_i = a; wdata_i = d;
        re1_i = e1; raddr1_i = a1; re2_i = e2; raddr2_i = a2;
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic e, input logic [4:0] a);
        if (rst || !e || a == 5'd0) return 32'h0;
        if (wreg_i && rw_i == a) return wdata_i;
        return arch[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) arch[i] = 32'h0;
            pend_valid = 1'b0;
            model_cnt  = 32'h0;
        end else begin
            if (pend_valid && pend_addr != 5'd0) model_cnt = model_cnt + 32'd1;
            if (stall_i) begin
                pend_valid = 1'b0;
            end else begin
                pend_valid = wreg_i;
                pend_addr  = rw_i;
                pend_data  = wdata_i;
                if (wreg_i && rw_i != 5'd0) arch[rw_i] = wdata_i;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; stall_i = 1'b0; wreg_i = 1'b0; rw_i = '0; wdata_i = '0;
        re1_i = 1'b0; re2_i = 1'b0; raddr1_i = '0; raddr2_i = '0;

        // reset: reads are forced to zero while rst is high, state clears on the edge
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 1, 5'd3, 32'hDEAD_BEEF, 1, 5'd3, 1, 5'd3);
            check("rst_rd1", c, rdata1_o, 32'h0);
            check("rst_rd2", c, rdata2_o, 32'h0);
        end
        for (int a = 1; a < 32; a++) begin
            drive(0, 0, 0, 5'd0, 32'h0, 1, 5'(a), 1, 5'(32 - a));
            check("post_rst_rd1", a, rdata1_o, 32'h0);
            check("post_rst_rd2", a, rdata2_o, 32'h0);
            check("post_rst_valid", a, 32'(wb_valid_o), 32'h0);
            check("post_rst_cnt", a, commit_cnt_o, 32'h0);
        end

        vecs[0]  = mk(0,0,1,5'd5,32'h1234_5678, 1,5'd5, 1,5'd0, 32'h1234_5678, 32'h0,          0, 0);
        vecs[1]  = mk(0,0,0,5'd0,32'h0,         1,5'd5, 1,5'd5, 32'h1234_5678, 32'h1234_5678,  1, 0);
        vecs[2]  = mk(0,0,0,5'd0,32'h0,         1,5'd5, 0,5'd5, 32'h1234_5678, 32'h0,          0, 1);
        vecs[3]  = mk(0,0,1,5'd7,32'hA,         1,5'd7, 1,5'd7, 32'hA,         32'hA,          0, 1);
        vecs[4]  = mk(0,0,1,5'd7,32'hB,         1,5'd7, 1,5'd7, 32'hB,         32'hB,          1, 1);
        vecs[5]  = mk(0,0,0,5'd0,32'h0,         1,5'd7, 1,5'd7, 32'hB,         32'hB,          1, 2);
        vecs[6]  = mk(0,0,0,5'd0,32'h0,         1,5'd7, 1,5'd5, 32'hB,         32'h1234_5678,  0, 3);
        vecs[7]  = mk(0,0,1,5'd0,32'hFFFF_FFFF, 1,5'd0, 1,5'd0, 32'h0,         32'h0,          0, 3);
        vecs[8]  = mk(0,0,0,5'd0,32'h0,         1,5'd0, 1,5'd0, 32'h0,         32'h0,          1, 3);
        vecs[9]  = mk(0,0,0,5'd0,32'h0,         1,5'd0, 1,5'd5, 32'h0,         32'h1234_5678,  0, 3);
        vecs[10] = mk(0,0,1,5'd3,32'h55,        1,5'd3, 1,5'd4, 32'h55,        32'h0,          0, 3);
        vecs[11] = mk(0,1,1,5'd4,32'h66,        1,5'd3, 1,5'd4, 32'h55,        32'h66,         1, 3);
        vecs[12] = mk(0,1,1,5'd4,32'h66,        1,5'd3, 1,5'd4, 32'h55,        32'h66,         0, 4);
        vecs[13] = mk(0,1,1,5'd4,32'h66,        1,5'd3, 1,5'd4, 32'h55,        32'h66,         0, 4);
        vecs[14] = mk(0,0,0,5'd0,32'h0,         1,5'd4, 1,5'd3, 32'h0,         32'h55,         0, 4);
        vecs[15] = mk(0,0,1,5'd4,32'h66,        1,5'd4, 1,5'd3, 32'h66,        32'h55,         0, 4);
        vecs[16] = mk(0,0,0,5'd0,32'h0,         1,5'd4, 1,5'd4, 32'h66,        32'h66,         1, 4);
        vecs[17] = mk(0,0,0,5'd0,32'h0,         1,5'd4, 1,5'd3, 32'h66,        32'h55,         0, 5);
        vecs[18] = mk(0,0,1,5'd9,32'h99,        1,5'd9, 1,5'd5, 32'h99,        32'h1234_5678,  0, 5);
        vecs[19] = mk(1,0,0,5'd0,32'h0,         1,5'd9, 1,5'd9, 32'h0,         32'h0,          1, 5);
        vecs[20] = mk(0,0,0,5'd0,32'h0,         1,5'd9, 1,5'd5, 32'h0,         32'h0,          0, 0);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].wreg, vecs[i].rw, vecs[i].wdata,
                  vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
            check("vec_rd1",   i, rdata1_o, vecs[i].exp1);
            check("vec_rd2",   i, rdata2_o, vecs[i].exp2);
            check("vec_valid", i, 32'(wb_valid_o), 32'(vecs[i].exp_valid));
            check("vec_cnt",   i, commit_cnt_o, vecs[i].exp_cnt);
        end

        // last table row leaves the DUT freshly reset with an empty WB latch
        for (int i = 0; i < 32; i++) arch[i] = 32'h0;
        pend_valid = 1'b0;
        pend_addr  = '0;
        pend_data  = '0;
        model_cnt  = 32'h0;

        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)));
            check("rnd_rd1",   c, rdata1_o, model_read(re1_i, raddr1_i));
            check("rnd_rd2",   c, rdata2_o, model_read(re2_i, raddr2_i));
            check("rnd_valid", c, 32'(wb_valid_o), 32'(pend_valid));
            check("rnd_cnt",   c, commit_cnt_o, model_cnt);
            if (pend_valid) begin
                check("rnd_wb_addr", c, 32'(wb_addr_o), 32'(pend_addr));
                check("rnd_wb_data", c, wb_data_o, pend_data);
            end
            model_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
